// File: rtl/sequence_detector.sv
// Serial bit-pattern detector.
// Samples one bit per clock on i and raises o for one cycle after the edge on which the
// last LEN sampled bits equal PATTERN (PATTERN[LEN-1] arrives first, PATTERN[0] last).
// Legal LEN range is 2..16.
//
// Optional feature: define SD_MATCH_COUNT_EN to add an 8-bit saturating match counter on
// port match_count. Without the macro the port and its logic are absent and o is unchanged.
module sequence_detector #(
   parameter int unsigned    LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1101,
   parameter bit             OVERLAP = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i,
   output logic o
`ifdef SD_MATCH_COUNT_EN
   ,
   output logic [7:0] match_count
`endif
);

   // fill counts valid bits since reset/clear so that leading reset zeros never form a match
   localparam int unsigned      FillW    = $clog2(LEN + 1);
   localparam logic [FillW-1:0] FillFull = FillW'(LEN);

   logic [LEN-1:0]   hist_q, hist_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic             o_q;
   logic             match;

   // Next history/fill and the match decision for the bit being sampled this edge
   always_comb begin
      hist_d = {hist_q[LEN-2:0], i};
      fill_d = (fill_q == FillFull) ? FillFull : fill_q + 1'b1;
      match  = (fill_d == FillFull) && (hist_d == PATTERN);
   end

   // History, fill and registered match pulse; reset wins over a simultaneous match
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
         o_q    <= 1'b0;
      end else begin
         o_q <= match;
         if (match && !OVERLAP) begin
            // Non-overlapping mode: the next match must be built from LEN fresh bits
            hist_q <= '0;
            fill_q <= '0;
         end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
         end
      end
   end

   assign o = o_q;

`ifdef SD_MATCH_COUNT_EN
   logic [7:0] count_q;

   // Saturating count of match pulses; clears only on reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else if (match && (count_q != 8'hFF)) begin
         count_q <= count_q + 8'd1;
      end
   end

   assign match_count = count_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Scoreboard bench for sequence_detector: three instances (default, non-overlapping,
// all-zero pattern) share one stimulus stream; a window-of-bits reference model pushes the
// expected outputs, and a monitor pops and compares them after every clock edge.
module tb_sequence_detector;

   logic clk_tb = 1'b0;
   logic rst_n;
   logic i;
   logic o_a, o_b, o_c;
`ifdef SD_MATCH_COUNT_EN
   logic [7:0] cnt_a, cnt_b, cnt_c;
`endif

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk_tb = ~clk_tb;

   sequence_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) u_dut_a (
      .clk         (clk_tb),
      .rst_n       (rst_n),
      .i           (i),
      .o           (o_a)
`ifdef SD_MATCH_COUNT_EN
      ,
      .match_count (cnt_a)
`endif
   );

   sequence_detector #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) u_dut_b (
      .clk         (clk_tb),
      .rst_n       (rst_n),
      .i           (i),
      .o           (o_b)
`ifdef SD_MATCH_COUNT_EN
      ,
      .match_count (cnt_b)
`endif
   );

   sequence_detector #(.LEN(4), .PATTERN(4'b0000), .OVERLAP(1'b1)) u_dut_c (
      .clk         (clk_tb),
      .rst_n       (rst_n),
      .i           (i),
      .o           (o_c)
`ifdef SD_MATCH_COUNT_EN
      ,
      .match_count (cnt_c)
`endif
   );

   // Scoreboard queues: expected o and expected match count per instance
   bit exp_a[$], exp_b[$], exp_c[$];
   int cexp_a[$], cexp_b[$], cexp_c[$];

   // Reference model state: list of valid bits since last reset/clear (oldest first)
   bit win_a[$], win_b[$], win_c[$];
   int mc_a = 0, mc_b = 0, mc_c = 0;

   // True when the window holds exactly 4 bits spelling pat, first-arrived bit = pat[3]
   function automatic bit window_hits(input bit w[$], input logic [3:0] pat);
      if (w.size() != 4) return 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (w[k] != pat[3-k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // Advance the model of instance k by one edge and push its expected outputs
   task automatic step_one(input int k, input bit r, input bit b);
      bit         w[$];
      int         c;
      bit         m;
      logic [3:0] pat;
      bit         ovl;
      pat = (k == 2) ? 4'b0000 : 4'b1101;
      ovl = (k != 1);
      case (k)
         0:       begin w = win_a; c = mc_a; end
         1:       begin w = win_b; c = mc_b; end
         default: begin w = win_c; c = mc_c; end
      endcase
      m = 1'b0;
      if (!r) begin
         w.delete();
         c = 0;
      end else begin
         w.push_back(b);
         if (w.size() > 4) void'(w.pop_front());
         m = window_hits(w, pat);
         if (m && c < 255) c++;
         if (m && !ovl) w.delete();
      end
      case (k)
         0:       begin win_a = w; mc_a = c; exp_a.push_back(m); cexp_a.push_back(c); end
         1:       begin win_b = w; mc_b = c; exp_b.push_back(m); cexp_b.push_back(c); end
         default: begin win_c = w; mc_c = c; exp_c.push_back(m); cexp_c.push_back(c); end
      endcase
   endtask

   task automatic drive(input bit r, input bit b);
      @(negedge clk_tb);
      rst_n = r;
      i     = b;
      for (int k = 0; k < 3; k++) step_one(k, r, b);
   endtask

   // Drive n bits of v, most significant (first-arriving) first, with reset released
   task automatic drive_bits(input logic [31:0] v, input int n);
      for (int k = n - 1; k >= 0; k--) drive(1'b1, v[k]);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: after every rising edge, pop what the model expects and compare
   initial begin
      int ca, cb, cc;
      forever begin
         @(posedge clk_tb);
         #1;
         if (exp_a.size() != 0) begin
            check("o_a", {7'd0, o_a}, {7'd0, exp_a.pop_front()});
            check("o_b", {7'd0, o_b}, {7'd0, exp_b.pop_front()});
            check("o_c", {7'd0, o_c}, {7'd0, exp_c.pop_front()});
            ca = cexp_a.pop_front();
            cb = cexp_b.pop_front();
            cc = cexp_c.pop_front();
`ifdef SD_MATCH_COUNT_EN
            check("count_a", cnt_a, ca[7:0]);
            check("count_b", cnt_b, cb[7:0]);
            check("count_c", cnt_c, cc[7:0]);
`endif
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      i     = 1'b0;

      // Reset held for two edges with i toggling
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);

      // Basic stream: single pulse after the 4th bit
      drive_bits(32'b1101011000, 10);

      // Overlap stream: two pulses on the overlapping instance, one on the non-overlapping one
      drive(1'b0, 1'b0);
      drive_bits(32'b1101101, 7);

      // Reset mid-pattern discards partial history
      drive(1'b0, 1'b0);
      drive_bits(32'b110, 3);
      drive(1'b0, 1'b1);
      drive_bits(32'b1, 1);
      drive_bits(32'b1101, 4);

      // All-zero pattern needs four real zeros, then pulses every further zero
      drive(1'b0, 1'b0);
      drive_bits(32'b00000, 5);

      // Random stream with occasional resets
      drive(1'b0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         drive(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)));
      end

      // Count saturation: 300 back-to-back matches of 1101
      drive(1'b0, 1'b0);
      for (int n = 0; n < 300; n++) drive_bits(32'b1101, 4);
      drive_bits(32'b00, 2);

      // Drain the scoreboard with a bounded wait
      repeat (3) @(posedge clk_tb);
      #2;
      if (exp_a.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_a.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
